itrx_aib_phy_bsr_ctrl: RTL and testbench
========================================

Name: itrx_aib_phy_bsr_ctrl

Overview:
- Boundary-scan chain sequencer: the initiator side of the JTAG boundary-cell interface.
- Generates jtag_clkdr, jtag_scan_en, jtag_intest, jtag_mode and serial si for a chain of AIB boundary cells, and collects the chain's serial so.
- Performs an optional capture pulse followed by a CHAIN_LEN-bit shift, giving parallel write/read of the whole chain.
- Sits between the test/DFT register block and the AIB I/O boundary-cell chain.

Parameters:
- CHAIN_LEN, 16, number of boundary cells in the chain; legal 2..256.
- DIV, 2, clk cycles per jtag_clkdr half-period; legal 1..15.

Ports:
- clk  in  1  sequencer clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cap_en  in  1  issue one capture pulse before shifting; latched at start.
- intest_req  in  1  jtag_intest value for the operation; latched at start.
- mode_req  in  1  jtag_mode value; latched at start, held after done.
- wr_data  in  CHAIN_LEN  parallel data to shift in; latched at start.
- so  in  1  serial out of the last chain cell.
- jtag_clkdr  out  1  boundary-cell data clock.
- jtag_scan_en  out  1  chain shift enable.
- jtag_intest  out  1  chain capture select.
- jtag_mode  out  1  chain drive select.
- si  out  1  serial in to cell 0.
- rd_data  out  CHAIN_LEN  parallel data shifted out.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous and immediate, including mid-operation: all outputs 0, rd_data=0, FSM=IDLE, all counters 0.
  - jtag_clkdr drops low with no partial pulse completed.
- All outputs are registered.
- FSM states: IDLE, CAPTURE, SHIFT, FINISH.
- Pulse: one LOW phase (DIV cycles, clkdr=0) followed by one HIGH phase (DIV cycles, clkdr=1).
  - si, jtag_scan_en and jtag_intest change only on the first cycle of a LOW phase.
- Start (IDLE, start=1 at edge E0):
  - latch wr_data, cap_en, intest_req and mode_req;
  - busy=1 from E0+1;
  - jtag_mode and jtag_intest take the latched values at E0+1.
  - Next state is CAPTURE if cap_en, else SHIFT.
- CAPTURE: one pulse with jtag_scan_en=0, then SHIFT.
- SHIFT: exactly CHAIN_LEN pulses with jtag_scan_en=1.
  - si for pulse k (k=0..CHAIN_LEN-1) = wr_data[CHAIN_LEN-1-k].
  - After the shift, cell i holds wr_data[i]; cell 0 is nearest si.
- so sampling: so is sampled on the last cycle of each SHIFT LOW phase, i.e. immediately before the rising edge.
  - rd_data[CHAIN_LEN-1-k] = so sampled before pulse k.
  - Therefore rd_data[i] = the pre-shift content of cell i.
  - rd_data updates as one parallel word when FINISH is entered and holds until the next done.
- FINISH: one cycle.
  - jtag_scan_en=0, jtag_intest=0, si=0, clkdr=0.
  - done=1 and busy=0 in this same cycle; next state IDLE.
  - jtag_mode keeps the latched value until the next start or reset.
- Latency: done asserts at E0 + 1 + 2·DIV·(CHAIN_LEN + cap_en).
- Back-to-back: start is accepted in the cycle after done.
- start while busy: ignored, with no latching and no effect on the running operation.
- Counters: bit counter width is clog2(CHAIN_LEN+1); phase counter width is 4 bits.
  - No wrap occurs within legal parameter ranges.

Test Plan:
1. Reset: assert rst mid-SHIFT (pulse 5, clkdr high) → same-cycle jtag_clkdr=0, busy=0, rd_data=0; a new start afterwards completes normally.
2. Shift only: CHAIN_LEN=16, DIV=2, chain model of 16 output cells preloaded 0x1234, wr_data=0xA5C3, cap_en=0, mode_req=1 → done at E0+65; rd_data=0x1234; cells=0xA5C3; jtag_mode=1; exactly 16 clkdr rising edges.
3. Capture with intest: cells' d_i=0x0F0F, cap_en=1, intest_req=1, wr_data=0 → first pulse has scan_en=0 and intest=1; rd_data=0x0F0F; done at E0+69.
4. Capture without intest: cap_en=1, intest_req=0, cells preloaded 0x00FF → cells hold on the capture pulse; rd_data=0x00FF.
5. start pulsed during busy with different wr_data → ignored; first result is unchanged; exactly one done.
6. DIV=1, CHAIN_LEN=2, back-to-back starts → clkdr period is 2 cycles; second start is accepted the cycle after done; si setup holds ≥1 cycle before each rising edge.

Source files
------------

// File: rtl/itrx_aib_phy_bsr_ctrl.sv
// Boundary-scan chain sequencer: optional capture pulse, then a CHAIN_LEN-bit
// shift that writes wr_data into the AIB boundary cells and reads their old content.
module itrx_aib_phy_bsr_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int DIV       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cap_en,
    input  logic                 intest_req,
    input  logic                 mode_req,
    input  logic [CHAIN_LEN-1:0] wr_data,
    input  logic                 so,
    output logic                 jtag_clkdr,
    output logic                 jtag_scan_en,
    output logic                 jtag_intest,
    output logic                 jtag_mode,
    output logic                 si,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 busy,
    output logic                 done
);
    localparam int              BW       = $clog2(CHAIN_LEN + 1);
    localparam logic [3:0]      PH_LAST  = 4'(DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, FINISH} state_t;

    state_t               state, state_nxt;
    logic [3:0]           ph_cnt, ph_cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [CHAIN_LEN-1:0] sh, sh_nxt, rd_nxt;
    logic                 clkdr_nxt, scan_en_nxt, intest_nxt, mode_nxt, si_nxt;
    logic                 busy_nxt, done_nxt;
    logic                 phase_end, pulse_end, last_bit;

    assign phase_end = (ph_cnt == PH_LAST);
    assign pulse_end = phase_end && jtag_clkdr;
    assign last_bit  = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ph_cnt       <= '0;
            bit_cnt      <= '0;
            sh           <= '0;
            rd_data      <= '0;
            jtag_clkdr   <= 1'b0;
            jtag_scan_en <= 1'b0;
            jtag_intest  <= 1'b0;
            jtag_mode    <= 1'b0;
            si           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            ph_cnt       <= ph_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            sh           <= sh_nxt;
            rd_data      <= rd_nxt;
            jtag_clkdr   <= clkdr_nxt;
            jtag_scan_en <= scan_en_nxt;
            jtag_intest  <= intest_nxt;
            jtag_mode    <= mode_nxt;
            si           <= si_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cap_en ? CAPTURE : SHIFT;
            CAPTURE: if (pulse_end) state_nxt = SHIFT;
            SHIFT:   if (pulse_end && last_bit) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sh holds the data still to be shifted out on si; so samples enter at the
    // LSB end as bits leave the MSB end, so after the last pulse it is the read word.
    always_comb begin
        ph_cnt_nxt  = ph_cnt;
        bit_cnt_nxt = bit_cnt;
        sh_nxt      = sh;
        rd_nxt      = rd_data;
        clkdr_nxt   = jtag_clkdr;
        scan_en_nxt = jtag_scan_en;
        intest_nxt  = jtag_intest;
        mode_nxt    = jtag_mode;
        si_nxt      = si;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sh_nxt      = wr_data;
                    ph_cnt_nxt  = '0;
                    bit_cnt_nxt = '0;
                    clkdr_nxt   = 1'b0;
                    scan_en_nxt = !cap_en;
                    si_nxt      = cap_en ? 1'b0 : wr_data[CHAIN_LEN-1];
                    intest_nxt  = intest_req;
                    mode_nxt    = mode_req;
                    busy_nxt    = 1'b1;
                end
            end
            CAPTURE, SHIFT: begin
                if (phase_end) begin
                    ph_cnt_nxt = '0;
                    clkdr_nxt  = ~jtag_clkdr;
                    if (state == SHIFT && !jtag_clkdr)
                        sh_nxt = {sh[CHAIN_LEN-2:0], so};
                    if (jtag_clkdr) begin
                        if (state == CAPTURE) begin
                            scan_en_nxt = 1'b1;
                            si_nxt      = sh[CHAIN_LEN-1];
                        end else if (last_bit) begin
                            bit_cnt_nxt = '0;
                            rd_nxt      = sh;
                            scan_en_nxt = 1'b0;
                            intest_nxt  = 1'b0;
                            si_nxt      = 1'b0;
                            busy_nxt    = 1'b0;
                            done_nxt    = 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BW'(1);
                            si_nxt      = sh[CHAIN_LEN-1];
                        end
                    end
                end else begin
                    ph_cnt_nxt = ph_cnt + 4'd1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_itrx_aib_phy_bsr_ctrl.sv
// Bench for the boundary-scan sequencer: two instances (16 cells/DIV 2 and
// 2 cells/DIV 1), each driving a behavioural boundary-cell chain.
module tb_itrx_aib_phy_bsr_ctrl;
    localparam int N1 = 16;
    localparam int D1 = 2;
    localparam int N2 = 2;
    localparam int D2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] cells;
        int          e0;
        int          lat;
        int          pulses;
        logic        mode;
        logic        first_se;
        logic        first_it;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp2_q[$];

    // ---------------- instance 1: 16 cells, DIV=2 ----------------
    logic          start1 = 1'b0, cap1 = 1'b0, it1 = 1'b0, mode1 = 1'b0;
    logic [N1-1:0] wr1 = '0;
    logic          so1, clkdr1, se1, jint1, jmode1, si1, busy1, done1;
    logic [N1-1:0] rd1;
    logic [N1-1:0] cells1 = '0, d1 = '0, load_val1 = '0;
    logic          load1 = 1'b0;

    itrx_aib_phy_bsr_ctrl #(.CHAIN_LEN(N1), .DIV(D1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .cap_en(cap1), .intest_req(it1),
        .mode_req(mode1), .wr_data(wr1), .so(so1), .jtag_clkdr(clkdr1),
        .jtag_scan_en(se1), .jtag_intest(jint1), .jtag_mode(jmode1), .si(si1),
        .rd_data(rd1), .busy(busy1), .done(done1)
    );

    // cell 0 is nearest si, so comes from the last cell
    assign so1 = cells1[N1-1];
    always @(posedge clkdr1 or posedge load1) begin
        if (load1)      cells1 <= load_val1;
        else if (se1)   cells1 <= {cells1[N1-2:0], si1};
        else if (jint1) cells1 <= d1;
    end

    // ---------------- instance 2: 2 cells, DIV=1 ----------------
    logic          start2 = 1'b0, cap2 = 1'b0, it2 = 1'b0, mode2 = 1'b0;
    logic [N2-1:0] wr2 = '0;
    logic          so2, clkdr2, se2, jint2, jmode2, si2, busy2, done2;
    logic [N2-1:0] rd2;
    logic [N2-1:0] cells2 = '0, d2 = '0, load_val2 = '0;
    logic          load2 = 1'b0;

    itrx_aib_phy_bsr_ctrl #(.CHAIN_LEN(N2), .DIV(D2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .cap_en(cap2), .intest_req(it2),
        .mode_req(mode2), .wr_data(wr2), .so(so2), .jtag_clkdr(clkdr2),
        .jtag_scan_en(se2), .jtag_intest(jint2), .jtag_mode(jmode2), .si(si2),
        .rd_data(rd2), .busy(busy2), .done(done2)
    );

    assign so2 = cells2[N2-1];
    always @(posedge clkdr2 or posedge load2) begin
        if (load2)      cells2 <= load_val2;
        else if (se2)   cells2 <= {cells2[N2-2:0], si2};
        else if (jint2) cells2 <= d2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor 1 ----------------
    int   dones1 = 0;
    int   exp_dones1 = 0;
    int   rises1 = 0;
    logic clkdr1_prev = 1'b0;
    logic fse1 = 1'b0, fit1 = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rises1      = 0;
                clkdr1_prev = 1'b0;
            end else begin
                if (clkdr1 && !clkdr1_prev) begin
                    if (rises1 == 0) begin
                        fse1 = se1;
                        fit1 = jint1;
                    end
                    rises1++;
                end
                clkdr1_prev = clkdr1;
                if (done1) begin
                    dones1++;
                    chk("exp1_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rd_data1", 32'(rd1), 32'(e.rd));
                        chk("cells1", 32'(cells1), 32'(e.cells));
                        chk("latency1", 32'(cyc + 1 - e.e0), 32'(e.lat));
                        chk("pulses1", 32'(rises1), 32'(e.pulses));
                        chk("jtag_mode1", 32'(jmode1), 32'(e.mode));
                        chk("first_scan_en1", 32'(fse1), 32'(e.first_se));
                        chk("first_intest1", 32'(fit1), 32'(e.first_it));
                        chk("finish_outs1", 32'({busy1, se1, jint1, si1, clkdr1}), 32'd0);
                    end
                    rises1 = 0;
                end
            end
        end
    end

    // ---------------- monitor 2 ----------------
    int   dones2 = 0;
    int   rises2_total = 0;
    int   per_err2 = 0;
    int   setup_err2 = 0;
    int   last_rise2 = -1;
    logic clkdr2_prev = 1'b0;
    logic si2_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                clkdr2_prev = 1'b0;
                last_rise2  = -1;
            end else begin
                if (clkdr2 && !clkdr2_prev) begin
                    rises2_total++;
                    if (last_rise2 >= 0 && cyc - last_rise2 != 2) per_err2++;
                    last_rise2 = cyc;
                    if (si2 !== si2_prev) setup_err2++;
                end
                clkdr2_prev = clkdr2;
                si2_prev    = si2;
                if (done2) begin
                    dones2++;
                    last_rise2 = -1;
                    chk("exp2_pending", 32'(exp2_q.size() > 0), 32'd1);
                    if (exp2_q.size() > 0) begin
                        e = exp2_q.pop_front();
                        chk("rd_data2", 32'(rd2), 32'(e.rd));
                        chk("cells2", 32'(cells2), 32'(e.cells));
                        chk("latency2", 32'(cyc + 1 - e.e0), 32'(e.lat));
                        chk("jtag_mode2", 32'(jmode2), 32'(e.mode));
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic op1(input logic [15:0] pre, input logic [15:0] dval, input logic [15:0] wr,
                       input logic cap, input logic it, input logic md,
                       input logic [15:0] erd, input logic [15:0] ecells, input int lat);
        exp_t e;
        @(negedge clk);
        load_val1 = pre;
        d1        = dval;
        load1     = 1'b1;
        #1 load1  = 1'b0;
        wr1 = wr; cap1 = cap; it1 = it; mode1 = md;
        start1 = 1'b1;
        e.rd = erd; e.cells = ecells; e.e0 = cyc + 1; e.lat = lat;
        e.pulses = N1 + (cap ? 1 : 0); e.mode = md; e.first_se = !cap; e.first_it = it;
        exp_q.push_back(e);
        exp_dones1++;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic op2(input logic do_load, input logic [1:0] pre, input logic [1:0] dval,
                       input logic [1:0] wr, input logic cap, input logic it, input logic md,
                       input logic [1:0] erd, input logic [1:0] ecells, input int lat);
        exp_t e;
        @(negedge clk);
        d2 = dval;
        if (do_load) begin
            load_val2 = pre;
            load2     = 1'b1;
            #1 load2  = 1'b0;
        end
        wr2 = wr; cap2 = cap; it2 = it; mode2 = md;
        start2 = 1'b1;
        e.rd = 16'(erd); e.cells = 16'(ecells); e.e0 = cyc + 1; e.lat = lat;
        e.pulses = 0; e.mode = md; e.first_se = 1'b0; e.first_it = 1'b0;
        exp2_q.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int limit);
        int n = 0;
        logic seen = 1'b0;
        while (n < limit && !seen) begin
            @(negedge clk);
            seen = (which == 1) ? done1 : done2;
            n++;
        end
        chk((which == 1) ? "done1_seen" : "done2_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic prev;

        #1 rst = 1'b1;
        #1;
        chk("reset_outs1", 32'({clkdr1, se1, jint1, jmode1, si1, busy1, done1}), 32'd0);
        chk("reset_rd1", 32'(rd1), 32'd0);
        chk("reset_outs2", 32'({clkdr2, se2, jint2, jmode2, si2, busy2, done2, rd2}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // shift only
        op1(16'h1234, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 1'b1, 16'h1234, 16'hA5C3, 65);
        wait_done(1, 200);
        repeat (3) @(negedge clk);

        // reset in the middle of the shift, high phase of pulse 5
        op1(16'hBEEF, 16'h0000, 16'h1111, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h1111, 65);
        r = 0;
        prev = clkdr1;
        for (int i = 0; i < 100 && r < 6; i++) begin
            @(negedge clk);
            if (clkdr1 && !prev) r++;
            prev = clkdr1;
        end
        chk("rst_at_pulse5", 32'(r), 32'd6);
        chk("pre_rst_clkdr1", 32'(clkdr1), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_clkdr1", 32'(clkdr1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_rd1", 32'(rd1), 32'd0);
        chk("rst_other1", 32'({se1, jint1, jmode1, si1, done1}), 32'd0);
        exp_q.delete();
        exp_dones1--;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // capture with intest loads d; capture without intest holds
        op1(16'hFFFF, 16'h0F0F, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0F0F, 16'h0000, 69);
        wait_done(1, 200);
        repeat (3) @(negedge clk);
        op1(16'h00FF, 16'hAAAA, 16'h3C3C, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h3C3C, 69);
        wait_done(1, 200);
        repeat (3) @(negedge clk);

        // start while busy is ignored
        op1(16'h8001, 16'h0000, 16'h7E7E, 1'b0, 1'b0, 1'b0, 16'h8001, 16'h7E7E, 65);
        repeat (10) @(negedge clk);
        wr1 = 16'hFFFF; cap1 = 1'b1; it1 = 1'b1; mode1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 200);
        repeat (20) @(negedge clk);

        // DIV=1, two cells, back-to-back
        op2(1'b1, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 5);
        wait_done(2, 50);
        op2(1'b0, 2'b00, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 2'b11, 7);
        wait_done(2, 50);
        repeat (5) @(negedge clk);

        chk("done_count1", 32'(dones1), 32'(exp_dones1));
        chk("done_count2", 32'(dones2), 32'd2);
        chk("clkdr2_rises", 32'(rises2_total), 32'd5);
        chk("clkdr2_period_errs", 32'(per_err2), 32'd0);
        chk("si2_setup_errs", 32'(setup_err2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
